// File: rtl/loop_nest_sequencer_pkg.sv
// Shared types for the three-level loop-nest index sequencer.
package seq_pkg;

  localparam int unsigned SEQ_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/loop_nest_sequencer_loop_level.sv
// One dimension of the loop nest: index register, latched bound and step,
// with an inc input and a wrap output that feeds the next outer level.
module loop_level #(
  parameter int unsigned Bits = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_load,
  input  logic [Bits-1:0] i_bound,
  input  logic [Bits-1:0] i_step,
  input  logic            i_inc,
  output logic [Bits-1:0] o_idx,
  output logic            o_wrap,
  output logic            o_end_nxt
);

  logic [Bits-1:0] r_idx;
  logic [Bits-1:0] r_bound;
  logic [Bits-1:0] r_step;

  logic [Bits:0]   w_sum;
  logic            w_at_end;
  logic [Bits-1:0] w_idx_nxt;
  logic [Bits-1:0] w_bound_nxt;
  logic [Bits-1:0] w_step_nxt;
  logic [Bits:0]   w_sum_nxt;

  // Sums carry one extra bit so bounds near 2^Bits-1 cannot overflow.
  assign w_sum    = {1'b0, r_idx} + {1'b0, r_step};
  assign w_at_end = (w_sum >= {1'b0, r_bound});
  assign o_wrap   = i_inc & w_at_end;

  always_comb begin
    w_idx_nxt = r_idx;
    if (i_load) begin
      w_idx_nxt = '0;
    end else if (i_inc) begin
      w_idx_nxt = w_at_end ? '0 : w_sum[Bits-1:0];
    end
  end

  assign w_bound_nxt = i_load ? i_bound : r_bound;
  assign w_step_nxt  = i_load ? i_step  : r_step;
  assign w_sum_nxt   = {1'b0, w_idx_nxt} + {1'b0, w_step_nxt};
  // Lets the parent register last_o one cycle ahead of the tuple it marks.
  assign o_end_nxt   = (w_sum_nxt >= {1'b0, w_bound_nxt});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_load) begin
      r_bound <= i_bound;
      r_step  <= i_step;
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/loop_nest_sequencer.sv
// Row/column/channel walk controller: latches bounds on start, streams one
// index tuple per accepted beat, pulses done after the final beat.
module loop_nest_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned Bits = SEQ_BITS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [Bits-1:0] rows_i,
  input  logic [Bits-1:0] cols_i,
  input  logic [Bits-1:0] chans_i,
  input  logic [Bits-1:0] stride_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [Bits-1:0] row_o,
  output logic [Bits-1:0] col_o,
  output logic [Bits-1:0] chan_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef struct packed {
    logic [Bits-1:0] row;
    logic [Bits-1:0] col;
    logic [Bits-1:0] chan;
  } idx_t;

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic r_valid;
  logic r_busy;
  logic r_done;
  logic r_last;

  logic            w_bounds_ok;
  logic            w_load;
  logic            w_accept;
  logic [Bits-1:0] w_stride;
  logic [Bits-1:0] w_one;
  logic            w_chan_wrap;
  logic            w_col_wrap;
  logic            w_row_wrap;
  logic            w_chan_end;
  logic            w_col_end;
  logic            w_row_end;
  idx_t            w_idx;

  assign w_one       = {{(Bits-1){1'b0}}, 1'b1};
  assign w_bounds_ok = (|rows_i) & (|cols_i) & (|chans_i);
  assign w_load      = (r_state == IDLE) & start_i & w_bounds_ok;
  assign w_stride    = (stride_i == '0) ? w_one : stride_i;
  // Abort wins over a simultaneous accept, so the indices never advance.
  assign w_accept    = (r_state == RUN) & ready_i & ~abort_i;

  loop_level #(.Bits(Bits)) u_chan (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_load    (w_load),
    .i_bound   (chans_i),
    .i_step    (w_one),
    .i_inc     (w_accept),
    .o_idx     (w_idx.chan),
    .o_wrap    (w_chan_wrap),
    .o_end_nxt (w_chan_end)
  );

  loop_level #(.Bits(Bits)) u_col (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_load    (w_load),
    .i_bound   (cols_i),
    .i_step    (w_stride),
    .i_inc     (w_chan_wrap),
    .o_idx     (w_idx.col),
    .o_wrap    (w_col_wrap),
    .o_end_nxt (w_col_end)
  );

  loop_level #(.Bits(Bits)) u_row (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_load    (w_load),
    .i_bound   (rows_i),
    .i_step    (w_stride),
    .i_inc     (w_col_wrap),
    .o_idx     (w_idx.row),
    .o_wrap    (w_row_wrap),
    .o_end_nxt (w_row_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = w_bounds_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (w_row_wrap) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // All status outputs are flopped from the next-state decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == RUN);
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
      r_last  <= (w_state_nxt == RUN) & w_chan_end & w_col_end & w_row_end;
    end
  end

  assign valid_o = r_valid;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign last_o  = r_last;
  assign row_o   = w_idx.row;
  assign col_o   = w_idx.col;
  assign chan_o  = w_idx.chan;

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Scoreboard bench for loop_nest_sequencer: nested-loop reference model feeds
// an expected-beat queue that a negedge monitor drains.
module tb_loop_nest_sequencer;

  localparam int B = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         ready = 1'b0;
  logic [B-1:0] rows = '0, cols = '0, chans = '0, stride = '0;
  logic         valid, last, busy, done;
  logic [B-1:0] row, col, chan;

  typedef struct {
    int r;
    int c;
    int ch;
    bit last;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int exp_done = 0;
  bit mon_en = 1'b0;
  bit pend_done = 1'b0;
  bit held_vld = 1'b0;
  logic [3*B-1:0] held;

  always #5 clk = ~clk;

  loop_nest_sequencer #(.Bits(B)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .abort_i (abort),
    .rows_i  (rows),
    .cols_i  (cols),
    .chans_i (chans),
    .stride_i(stride),
    .ready_i (ready),
    .valid_o (valid),
    .row_o   (row),
    .col_o   (col),
    .chan_o  (chan),
    .last_o  (last),
    .busy_o  (busy),
    .done_o  (done)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the walk is just three nested loops over the bounds.
  task automatic build_model(input int r, input int c, input int ch, input int s);
    int st;
    beat_t b;
    st = (s == 0) ? 1 : s;
    for (int ri = 0; ri < r; ri += st)
      for (int ci = 0; ci < c; ci += st)
        for (int k = 0; k < ch; k++) begin
          b.r = ri; b.c = ci; b.ch = k; b.last = 1'b0;
          exp_q.push_back(b);
        end
    b = exp_q.pop_back();
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      beat_t e;
      if (pend_done) begin
        chk("done_after_last", done, 1);
        pend_done = 1'b0;
      end
      if (done) done_seen++;
      if (held_vld) begin
        chk("stall_valid_hold", valid, 1);
        chk("stall_tuple_hold", int'({row, col, chan}), int'(held));
        chk("stall_last_hold", last, e.last);
      end
      if (valid && ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_row", row, e.r);
          chk("beat_col", col, e.c);
          chk("beat_chan", chan, e.ch);
          chk("beat_last", last, e.last);
          if (e.last) pend_done = 1'b1;
        end
      end
      held_vld = valid && !ready && !abort;
      held = {row, col, chan};
      e.last = last;
    end
  end

  task automatic run_walk(input int r, input int c, input int ch, input int s,
                          input int stall_pct, input int abort_at, input bit poke_start);
    int n;
    int acc;
    bit finished;
    exp_q.delete();
    build_model(r, c, ch, s);
    n = exp_q.size();
    @(posedge clk); #1;
    start = 1'b1; rows = B'(r); cols = B'(c); chans = B'(ch); stride = B'(s);
    ready = ($urandom_range(99) >= stall_pct);
    @(posedge clk); #1;
    start = 1'b0;
    rows = B'($urandom); cols = B'($urandom); chans = B'($urandom); stride = B'($urandom);
    @(negedge clk);
    chk("first_valid", valid, 1);
    chk("first_tuple", int'({row, col, chan}), 0);
    chk("first_busy", busy, 1);
    acc = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (valid && ready) acc++;
      if (acc == n) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      ready = ($urandom_range(99) >= stall_pct);
      start = poke_start && (cyc == 3);
      if (start) begin
        rows = 1; cols = 1; chans = 1; stride = 1;
      end
      if (abort_at >= 0 && acc == abort_at) begin
        ready = 1'b1;
        abort = 1'b1;
      end
      @(negedge clk);
      if (abort) begin
        chk("abort_cycle_valid", valid, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk("abort_valid_drop", valid, 0);
        chk("abort_busy_drop", busy, 0);
        chk("abort_no_done", done, 0);
        exp_q.delete();
        @(posedge clk);
        return;
      end
    end
    if (!finished) begin
      chk("walk_timeout", acc, n);
      exp_q.delete();
      return;
    end
    exp_done++;
    @(posedge clk); #1;
    ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", valid, 0);
    chk("done_single", done, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic zero_walk(input int r, input int c, input int ch);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b1; rows = B'(r); cols = B'(c); chans = B'(ch); stride = 1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_valid", valid, 0);
    @(negedge clk);
    chk("zero_done_drop", done, 0);
    chk("zero_valid_idle", valid, 0);
  endtask

  task automatic reset_mid_walk();
    exp_q.delete();
    build_model(3, 3, 3, 1);
    @(posedge clk); #1;
    start = 1'b1; rows = 3; cols = 3; chans = 3; stride = 1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last, 0);
    chk("rst_tuple", int'({row, col, chan}), 0);
    exp_q.delete();
    pend_done = 1'b0;
    held_vld = 1'b0;
    ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", valid, 0);
  endtask

  initial begin
    #2;
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_last", last, 0);
    chk("reset_tuple", int'({row, col, chan}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_walk(2, 2, 3, 1, 0, -1, 1'b0);
    run_walk(5, 5, 1, 2, 0, -1, 1'b0);
    run_walk(5, 5, 1, 0, 0, -1, 1'b0);
    run_walk(2, 2, 3, 1, 40, -1, 1'b1);
    zero_walk(2, 2, 0);
    zero_walk(0, 3, 3);
    run_walk(1023, 1023, 1, 1000, 0, -1, 1'b0);
    run_walk(2, 2, 3, 1, 0, 4, 1'b0);
    run_walk(2, 2, 3, 1, 0, -1, 1'b0);
    reset_mid_walk();
    for (int i = 0; i < 6; i++) begin
      run_walk($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3),
               $urandom_range(0, 3), 30, -1, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("done_count", done_seen, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
